// File: rtl/traffic_phase_scheduler_if.sv
// Signal bundle between the sensor/emergency side and the scheduler:
// vehicle and emergency requests in, lamp codes and status out.
interface traffic_phase_scheduler_if;
  logic [3:0] req;
  logic       emerg;
  logic [1:0] emerg_dir;
  logic [2:0] m1;
  logic [2:0] m2;
  logic [2:0] m3;
  logic [2:0] m4;
  logic [1:0] phase;
  logic [1:0] cur_dir;

  modport master (
    output req, emerg, emerg_dir,
    input  m1, m2, m3, m4, phase, cur_dir
  );

  modport slave (
    input  req, emerg, emerg_dir,
    output m1, m2, m3, m4, phase, cur_dir
  );
endinterface

// File: rtl/traffic_phase_scheduler.sv
// Demand-driven four-approach phase scheduler. Round-robin service of
// presence requests with min/max green, yellow and all-red clearance,
// and emergency preemption. All lamp outputs are registered.
//
//   state     | meaning
//   ----------+-----------------------------------------------------
//   S_ALL_RED | every head red; grant of next approach on last cycle
//   S_GREEN   | approach cur is green
//   S_YELLOW  | approach cur is yellow, fixed length
module traffic_phase_scheduler #(
  parameter int GREEN_MIN = 8,
  parameter int GREEN_MAX = 32,
  parameter int YELLOW_T  = 4,
  parameter int ALLRED_T  = 2,
  parameter int TW        = 8
) (
  input logic                     clk,
  input logic                     rst,
  traffic_phase_scheduler_if.slave bus
);

  typedef enum logic [1:0] {
    S_ALL_RED = 2'b00,
    S_GREEN   = 2'b01,
    S_YELLOW  = 2'b10
  } state_t;

  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;

  localparam logic [TW-1:0] GMIN_LAST   = TW'(GREEN_MIN - 1);
  localparam logic [TW-1:0] GMAX_LAST   = TW'(GREEN_MAX - 1);
  localparam logic [TW-1:0] YEL_LAST    = TW'(YELLOW_T - 1);
  localparam logic [TW-1:0] ALLRED_LAST = TW'(ALLRED_T - 1);

  state_t        state_q, state_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [1:0]    cur_q, cur_d;
  logic [2:0]    m1_q, m2_q, m3_q, m4_q;
  logic [1:0]    phase_q;
  logic [1:0]    cur_dir_q;

  logic          other;
  logic          leave_green;

  // First requesting approach after c, wrapping; c itself is scanned last.
  // With no request at all the grant simply advances to c+1.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] c);
    logic [1:0] idx;
    rr_pick = c + 2'd1;
    for (int k = 4; k >= 1; k--) begin
      idx = c + 2'(k);
      if (r[idx]) rr_pick = idx;
    end
  endfunction

  // Lamp code for approach a; only the owning approach is ever non-red.
  function automatic logic [2:0] lamp(input state_t s, input logic [1:0] c,
                                      input logic [1:0] a);
    lamp = LAMP_RED;
    if (c == a) begin
      case (s)
        S_GREEN:  lamp = LAMP_GRN;
        S_YELLOW: lamp = LAMP_YEL;
        default:  lamp = LAMP_RED;
      endcase
    end
  endfunction

  // Next-state, timer and grant decision.
  always_comb begin
    state_d     = state_q;
    tmr_d       = tmr_q + 1'b1;
    cur_d       = cur_q;
    other       = |(bus.req & ~(4'b0001 << cur_q));
    leave_green = 1'b0;

    unique case (state_q)
      S_ALL_RED: begin
        if (tmr_q == ALLRED_LAST) begin
          state_d = S_GREEN;
          tmr_d   = '0;
          cur_d   = bus.emerg ? bus.emerg_dir : rr_pick(bus.req, cur_q);
        end
      end
      S_GREEN: begin
        // An emergency owning the green overrides the max-green limit.
        if (bus.emerg) begin
          leave_green = (bus.emerg_dir != cur_q);
        end else begin
          leave_green = ((tmr_q >= GMIN_LAST) && other) || (tmr_q == GMAX_LAST);
        end

        if (leave_green) begin
          state_d = S_YELLOW;
          tmr_d   = '0;
        end else if (tmr_q == GMAX_LAST) begin
          tmr_d = tmr_q;
        end
      end
      S_YELLOW: begin
        if (tmr_q == YEL_LAST) begin
          state_d = S_ALL_RED;
          tmr_d   = '0;
        end
      end
      default: begin
        state_d = S_ALL_RED;
        tmr_d   = '0;
      end
    endcase
  end

  // State, timer and registered lamp/status outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_ALL_RED;
      tmr_q     <= '0;
      cur_q     <= 2'd3;
      m1_q      <= LAMP_RED;
      m2_q      <= LAMP_RED;
      m3_q      <= LAMP_RED;
      m4_q      <= LAMP_RED;
      phase_q   <= 2'b00;
      cur_dir_q <= 2'd3;
    end else begin
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      cur_q     <= cur_d;
      m1_q      <= lamp(state_d, cur_d, 2'd0);
      m2_q      <= lamp(state_d, cur_d, 2'd1);
      m3_q      <= lamp(state_d, cur_d, 2'd2);
      m4_q      <= lamp(state_d, cur_d, 2'd3);
      phase_q   <= state_d;
      cur_dir_q <= cur_d;
    end
  end

  assign bus.m1      = m1_q;
  assign bus.m2      = m2_q;
  assign bus.m3      = m3_q;
  assign bus.m4      = m4_q;
  assign bus.phase   = phase_q;
  assign bus.cur_dir = cur_dir_q;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Directed bench for traffic_phase_scheduler at default parameters.
// Observed vector is {m1,m2,m3,m4,phase,cur_dir}.
module tb_traffic_phase_scheduler;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  logic started;

  traffic_phase_scheduler_if bus();

  traffic_phase_scheduler dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected vector: ph 0=all red, 1=green, 2=yellow on approach dir.
  function automatic logic [15:0] ev(input logic [1:0] ph, input logic [1:0] dir);
    logic [2:0] l [4];
    for (int i = 0; i < 4; i++) l[i] = 3'b100;
    if (ph == 2'b01) l[dir] = 3'b001;
    if (ph == 2'b10) l[dir] = 3'b010;
    return {l[0], l[1], l[2], l[3], ph, dir};
  endfunction

  function automatic logic [15:0] obs();
    return {bus.m1, bus.m2, bus.m3, bus.m4, bus.phase, bus.cur_dir};
  endfunction

  // Lamp-code legality and mutual exclusion every cycle.
  always @(negedge clk) begin
    if (started) begin
      int nonred;
      logic legal;
      logic [2:0] l [4];
      l[0] = bus.m1; l[1] = bus.m2; l[2] = bus.m3; l[3] = bus.m4;
      nonred = 0;
      legal  = 1'b1;
      for (int i = 0; i < 4; i++) begin
        if (l[i] !== 3'b100) nonred++;
        if (l[i] !== 3'b100 && l[i] !== 3'b010 && l[i] !== 3'b001) legal = 1'b0;
      end
      total++;
      if (!legal || nonred > 1) begin
        bad++;
        $display("FAIL safety t=%0t heads=%b %b %b %b required one non-red legal code at most",
                 $time, l[0], l[1], l[2], l[3]);
      end
    end
  end

  // Reset then release; returns at the first green sample.
  task automatic do_reset(input logic [3:0] r);
    rst = 1'b0;
    bus.req = r;
    bus.emerg = 1'b0;
    bus.emerg_dir = 2'd0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.req = 4'b0000;
    bus.emerg = 1'b0;
    bus.emerg_dir = 2'd0;
    @(negedge clk);
    started = 1'b1;
    total++;
    if (obs() !== ev(2'b00, 2'd3)) begin
      bad++; $display("FAIL reset_first got=%h exp=%h", obs(), ev(2'b00, 2'd3));
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    total++;
    if (obs() !== ev(2'b00, 2'd3)) begin
      bad++; $display("FAIL reset_hold got=%h exp=%h", obs(), ev(2'b00, 2'd3));
    end
    @(negedge clk);
    total++;
    if (obs() !== ev(2'b00, 2'd3)) begin
      bad++; $display("FAIL idle_allred got=%h exp=%h", obs(), ev(2'b00, 2'd3));
    end
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      total++;
      if (obs() !== ev(2'b01, 2'd0)) begin
        bad++; $display("FAIL idle_green1 cyc=%0d got=%h exp=%h", i, obs(), ev(2'b01, 2'd0));
      end
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++;
      if (obs() !== ev(2'b10, 2'd0)) begin
        bad++; $display("FAIL idle_yellow1 cyc=%0d got=%h exp=%h", i, obs(), ev(2'b10, 2'd0));
      end
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total++;
      if (obs() !== ev(2'b00, 2'd0)) begin
        bad++; $display("FAIL idle_allred1 cyc=%0d got=%h exp=%h", i, obs(), ev(2'b00, 2'd0));
      end
    end
    @(negedge clk);
    total++;
    if (obs() !== ev(2'b01, 2'd1)) begin
      bad++; $display("FAIL idle_green2 got=%h exp=%h", obs(), ev(2'b01, 2'd1));
    end
  endtask

  task automatic test_all_req();
    do_reset(4'b1111);
    for (int g = 0; g < 5; g++) begin
      for (int i = 0; i < 8; i++) begin
        total++;
        if (obs() !== ev(2'b01, 2'(g))) begin
          bad++; $display("FAIL allreq_green g=%0d cyc=%0d got=%h exp=%h", g, i, obs(), ev(2'b01, 2'(g)));
        end
        @(negedge clk);
      end
      if (g < 4) begin
        for (int i = 0; i < 4; i++) begin
          total++;
          if (obs() !== ev(2'b10, 2'(g))) begin
            bad++; $display("FAIL allreq_yellow g=%0d cyc=%0d got=%h exp=%h", g, i, obs(), ev(2'b10, 2'(g)));
          end
          @(negedge clk);
        end
        for (int i = 0; i < 2; i++) begin
          total++;
          if (obs() !== ev(2'b00, 2'(g))) begin
            bad++; $display("FAIL allreq_allred g=%0d cyc=%0d got=%h exp=%h", g, i, obs(), ev(2'b00, 2'(g)));
          end
          @(negedge clk);
        end
      end
    end
    bus.req = 4'b0000;
  endtask

  task automatic test_skip();
    do_reset(4'b0000);
    bus.req = 4'b0100;
    for (int i = 0; i < 8; i++) begin
      total++;
      if (obs() !== ev(2'b01, 2'd0)) begin
        bad++; $display("FAIL skip_green cyc=%0d got=%h exp=%h", i, obs(), ev(2'b01, 2'd0));
      end
      @(negedge clk);
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (obs() !== ev(2'b10, 2'd0)) begin
        bad++; $display("FAIL skip_yellow cyc=%0d got=%h exp=%h", i, obs(), ev(2'b10, 2'd0));
      end
      @(negedge clk);
    end
    for (int i = 0; i < 2; i++) begin
      total++;
      if (obs() !== ev(2'b00, 2'd0)) begin
        bad++; $display("FAIL skip_allred cyc=%0d got=%h exp=%h", i, obs(), ev(2'b00, 2'd0));
      end
      @(negedge clk);
    end
    total++;
    if (obs() !== ev(2'b01, 2'd2)) begin
      bad++; $display("FAIL skip_next_m3 got=%h exp=%h", obs(), ev(2'b01, 2'd2));
    end
    bus.req = 4'b0000;
  endtask

  task automatic test_emerg();
    do_reset(4'b0000);
    @(negedge clk);
    @(negedge clk);
    total++;
    if (obs() !== ev(2'b01, 2'd0)) begin
      bad++; $display("FAIL emerg_pre got=%h exp=%h", obs(), ev(2'b01, 2'd0));
    end
    bus.emerg = 1'b1;
    bus.emerg_dir = 2'd2;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++;
      if (obs() !== ev(2'b10, 2'd0)) begin
        bad++; $display("FAIL emerg_yellow cyc=%0d got=%h exp=%h", i, obs(), ev(2'b10, 2'd0));
      end
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total++;
      if (obs() !== ev(2'b00, 2'd0)) begin
        bad++; $display("FAIL emerg_allred cyc=%0d got=%h exp=%h", i, obs(), ev(2'b00, 2'd0));
      end
    end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      total++;
      if (obs() !== ev(2'b01, 2'd2)) begin
        bad++; $display("FAIL emerg_hold cyc=%0d got=%h exp=%h", i, obs(), ev(2'b01, 2'd2));
      end
    end
    // Held green is well past the minimum, so a waiting approach ends it at once.
    bus.emerg = 1'b0;
    bus.req = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++;
      if (obs() !== ev(2'b10, 2'd2)) begin
        bad++; $display("FAIL emerg_release_yellow cyc=%0d got=%h exp=%h", i, obs(), ev(2'b10, 2'd2));
      end
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total++;
      if (obs() !== ev(2'b00, 2'd2)) begin
        bad++; $display("FAIL emerg_release_allred cyc=%0d got=%h exp=%h", i, obs(), ev(2'b00, 2'd2));
      end
    end
    @(negedge clk);
    total++;
    if (obs() !== ev(2'b01, 2'd0)) begin
      bad++; $display("FAIL emerg_next_m1 got=%h exp=%h", obs(), ev(2'b01, 2'd0));
    end
    bus.req = 4'b0000;
  endtask

  task automatic test_reset_mid_yellow();
    do_reset(4'b0010);
    total++;
    if (obs() !== ev(2'b01, 2'd1)) begin
      bad++; $display("FAIL midy_first_m2 got=%h exp=%h", obs(), ev(2'b01, 2'd1));
    end
    bus.req = 4'b0001;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      total++;
      if (obs() !== ev(2'b01, 2'd1)) begin
        bad++; $display("FAIL midy_green cyc=%0d got=%h exp=%h", i, obs(), ev(2'b01, 2'd1));
      end
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total++;
      if (obs() !== ev(2'b10, 2'd1)) begin
        bad++; $display("FAIL midy_yellow cyc=%0d got=%h exp=%h", i, obs(), ev(2'b10, 2'd1));
      end
    end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (obs() !== ev(2'b00, 2'd3)) begin
      bad++; $display("FAIL midy_reset got=%h exp=%h", obs(), ev(2'b00, 2'd3));
    end
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (obs() !== ev(2'b00, 2'd3)) begin
      bad++; $display("FAIL midy_allred got=%h exp=%h", obs(), ev(2'b00, 2'd3));
    end
    @(negedge clk);
    total++;
    if (obs() !== ev(2'b01, 2'd0)) begin
      bad++; $display("FAIL midy_grant_m1 got=%h exp=%h", obs(), ev(2'b01, 2'd0));
    end
    bus.req = 4'b0000;
  endtask

  initial begin
    total = 0;
    bad = 0;
    started = 1'b0;
    rst = 1'b0;
    bus.req = 4'b0000;
    bus.emerg = 1'b0;
    bus.emerg_dir = 2'd0;
    test_reset();
    test_all_req();
    test_skip();
    test_emerg();
    test_reset_mid_yellow();
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
